// File: rtl/hdc_pkg.sv
// ============================================================================
//  Module      : hdc_pkg
//  Description : Shared types and constants for the encoder input path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hdc_pkg;

    localparam int DEFAULT_IN_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_DONE     = 2'd2,
        ST_WAIT_END = 2'd3
    } stream_state_e;

endpackage : hdc_pkg

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with flush, head shown combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 7
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int                c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL_CNT = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == c_FULL_CNT);
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign rdata_o = r_mem[r_rd_ptr];

    // Guard against overflow/underflow even if the caller forgets to.
    assign w_push = push_i && !full_o && !flush_i;
    assign w_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo

`default_nettype wire

// File: rtl/input_streamer.sv
// ============================================================================
//  Module      : input_streamer
//  Description : Buffers framed samples and feeds them to the encoder,
//                pulsing input_done_o once per frame. Optional statistics
//                counters are enabled with INPUT_STREAMER_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_streamer
    import hdc_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = DEFAULT_IN_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        soft_reset_i,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    input  logic [DATA_WIDTH-1:0]       s_data_i,
    input  logic                        s_last_i,
    input  logic                        running_i,
    output logic [DATA_WIDTH-1:0]       in_value_o,
    output logic                        in_valid_o,
    input  logic                        in_ready_i,
    output logic                        input_done_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o
`ifdef INPUT_STREAMER_STATS_EN
    ,
    output logic [15:0]                 frame_cnt_o,
    output logic [15:0]                 stall_cnt_o
`endif
);

    stream_state_e         r_state;
    stream_state_e         w_state_nxt;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH:0]   w_head;
    logic                  w_head_last;

    sync_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .WIDTH   (DATA_WIDTH + 1)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (soft_reset_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i ({s_last_i, s_data_i}),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (count_o)
    );

    assign w_head_last  = w_head[DATA_WIDTH];
    assign in_value_o   = w_head[DATA_WIDTH-1:0];
    assign s_ready_o    = !w_full;
    assign w_push       = s_valid_i && s_ready_o;
    assign in_valid_o   = (r_state == ST_STREAM) && !w_empty && running_i;
    assign w_pop        = in_valid_o && in_ready_i;
    assign input_done_o = (r_state == ST_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (running_i) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // Losing running_i mid-frame parks in IDLE; the FIFO keeps its data.
                if (!running_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_pop && w_head_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_WAIT_END;
            end
            ST_WAIT_END: begin
                if (!running_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else if (soft_reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef INPUT_STREAMER_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall     = (r_state == ST_STREAM) && !w_empty && !in_ready_i;
    assign frame_cnt_o = r_frame_cnt;
    assign stall_cnt_o = r_stall_cnt;

    // Frame count wraps; stall count saturates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frame_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (soft_reset_i) begin
            r_frame_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_state == ST_DONE) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule : input_streamer

`default_nettype wire

// File: tb/tb_input_streamer.sv
// ============================================================================
//  Module      : tb_input_streamer
//  Description : Directed self-checking bench for input_streamer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_streamer;

    localparam int c_DEPTH = 16;
    localparam int c_DW    = 6;

    logic                    clk;
    logic                    rst_n;
    logic                    soft_reset;
    logic                    s_valid;
    logic                    s_ready;
    logic [c_DW-1:0]         s_data;
    logic                    s_last;
    logic                    running;
    logic [c_DW-1:0]         in_value;
    logic                    in_valid;
    logic                    in_ready;
    logic                    input_done;
    logic [$clog2(c_DEPTH):0] count;
`ifdef INPUT_STREAMER_STATS_EN
    logic [15:0]             frame_cnt;
    logic [15:0]             stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    input_streamer #(
        .FIFO_DEPTH   (c_DEPTH),
        .DATA_WIDTH   (c_DW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .soft_reset_i (soft_reset),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .s_data_i     (s_data),
        .s_last_i     (s_last),
        .running_i    (running),
        .in_value_o   (in_value),
        .in_valid_o   (in_valid),
        .in_ready_i   (in_ready),
        .input_done_o (input_done),
        .count_o      (count)
`ifdef INPUT_STREAMER_STATS_EN
        ,
        .frame_cnt_o  (frame_cnt),
        .stall_cnt_o  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [c_DW-1:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

`ifdef INPUT_STREAMER_STATS_EN
    task automatic run_frame();
        push(6'd1, 1'b0);
        push(6'd2, 1'b1);
        running  = 1'b1;
        in_ready = 1'b0;
        tick();
        tick();
        tick();
        in_ready = 1'b1;
        tick();
        tick();
        tick();
        running  = 1'b0;
        in_ready = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        soft_reset = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        running    = 1'b0;
        in_ready   = 1'b0;
        repeat (3) tick();
        check("rst_count", 32'(count), 0);
        check("rst_in_valid", 32'(in_valid), 0);
        check("rst_done", 32'(input_done), 0);
        rst_n = 1'b1;
        tick();
        check("rst_s_ready", 32'(s_ready), 1);

        // Buffer a frame while the encoder is idle.
        push(6'd5, 1'b0);
        push(6'd9, 1'b0);
        push(6'd63, 1'b1);
        check("buf3_count", 32'(count), 3);
        check("buf3_in_valid", 32'(in_valid), 0);

        running  = 1'b1;
        in_ready = 1'b1;
        check("idle_in_valid", 32'(in_valid), 0);
        tick();
        check("s1_valid", 32'(in_valid), 1);
        check("s1_value", 32'(in_value), 5);
        tick();
        check("s2_value", 32'(in_value), 9);
        tick();
        check("s3_value", 32'(in_value), 63);
        check("s3_done_low", 32'(input_done), 0);
        tick();
        check("done_pulse", 32'(input_done), 1);
        check("done_in_valid", 32'(in_valid), 0);
        tick();
        check("done_single", 32'(input_done), 0);
        check("frame_empty", 32'(count), 0);
        running  = 1'b0;
        in_ready = 1'b0;
        tick();

        // Fill to full, then stream with continuous upstream traffic.
        for (int i = 0; i < 16; i++) begin
            push(6'(i), (i == 15));
        end
        check("full_count", 32'(count), 16);
        check("full_s_ready", 32'(s_ready), 0);
        in_ready = 1'b1;
        s_valid  = 1'b1;
        s_data   = 6'd40;
        s_last   = 1'b0;
        tick();
        check("full_hold", 32'(count), 16);
        running = 1'b1;
        tick();
        check("full_stream_valid", 32'(in_valid), 1);
        check("full_stream_head", 32'(in_value), 0);
        check("full_stream_cnt", 32'(count), 16);
        tick();
        check("pop_only_cnt", 32'(count), 15);
        check("pop_only_head", 32'(in_value), 1);
        tick();
        check("pushpop_cnt_a", 32'(count), 15);
        check("pushpop_head_a", 32'(in_value), 2);
        tick();
        check("pushpop_cnt_b", 32'(count), 15);
        check("pushpop_head_b", 32'(in_value), 3);
        soft_reset = 1'b1;
        s_valid    = 1'b0;
        running    = 1'b0;
        in_ready   = 1'b0;
        tick();
        soft_reset = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_s_ready", 32'(s_ready), 1);

        // Soft reset in STREAM beats a simultaneous push and pop.
        for (int i = 0; i < 7; i++) begin
            push(6'(i + 1), (i == 6));
        end
        running = 1'b1;
        tick();
        check("sr_pre_count", 32'(count), 7);
        check("sr_pre_valid", 32'(in_valid), 1);
        soft_reset = 1'b1;
        s_valid    = 1'b1;
        s_data     = 6'd30;
        in_ready   = 1'b1;
        tick();
        check("sr_count", 32'(count), 0);
        check("sr_in_valid", 32'(in_valid), 0);
        check("sr_done", 32'(input_done), 0);
        soft_reset = 1'b0;
        s_valid    = 1'b0;
        in_ready   = 1'b0;
        tick();
        check("sr_after_done", 32'(input_done), 0);
        check("sr_after_count", 32'(count), 0);
        running = 1'b0;
        tick();

        // Drop running mid-frame, then resume.
        push(6'd10, 1'b0);
        push(6'd11, 1'b0);
        push(6'd12, 1'b0);
        push(6'd13, 1'b1);
        running  = 1'b1;
        in_ready = 1'b1;
        tick();
        check("mid_v10", 32'(in_value), 10);
        tick();
        check("mid_v11", 32'(in_value), 11);
        tick();
        check("mid_v12", 32'(in_value), 12);
        running = 1'b0;
        #1;
        check("mid_drop_valid", 32'(in_valid), 0);
        check("mid_drop_count", 32'(count), 2);
        tick();
        check("mid_idle_valid", 32'(in_valid), 0);
        check("mid_idle_count", 32'(count), 2);
        running = 1'b1;
        tick();
        check("resume_valid", 32'(in_valid), 1);
        check("resume_v12", 32'(in_value), 12);
        tick();
        check("resume_v13", 32'(in_value), 13);
        tick();
        check("resume_done", 32'(input_done), 1);
        tick();
        check("resume_done_end", 32'(input_done), 0);
        check("resume_empty", 32'(count), 0);
        running  = 1'b0;
        in_ready = 1'b0;
        tick();

`ifdef INPUT_STREAMER_STATS_EN
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        check("stats_clr_frame", 32'(frame_cnt), 0);
        check("stats_clr_stall", 32'(stall_cnt), 0);
        run_frame();
        check("stats_frame1", 32'(frame_cnt), 1);
        check("stats_stall1", 32'(stall_cnt), 2);
        run_frame();
        check("stats_frame2", 32'(frame_cnt), 2);
        check("stats_stall2", 32'(stall_cnt), 4);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_input_streamer

`default_nettype wire

// File: doc/input_streamer.md
INPUT_STREAMER -- requirements
Module: input_streamer

Interface
REQ-001: The block SHALL have parameter FIFO_DEPTH, default 16, sample buffer entries (power of two, at least 2).
REQ-002: The block SHALL have parameter DATA_WIDTH, default 6, sample width matching the encoder input value.
REQ-003: The block SHALL have port clk_i, input, 1 bit, single clock, all state on its rising edge.
REQ-004: The block SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-005: The block SHALL have port soft_reset_i, input, 1 bit, synchronous flush of FIFO and FSM.
REQ-006: The block SHALL have port s_valid_i, input, 1 bit, upstream sample valid.
REQ-007: The block SHALL have port s_ready_o, output, 1 bit, upstream sample accepted.
REQ-008: The block SHALL have port s_data_i, input, DATA_WIDTH bits, upstream sample value.
REQ-009: The block SHALL have port s_last_i, input, 1 bit, marks the final sample of a frame.
REQ-010: The block SHALL have port running_i, input, 1 bit, encoder running flag.
REQ-011: The block SHALL have port in_value_o, output, DATA_WIDTH bits, sample presented to the encoder.
REQ-012: The block SHALL have port in_valid_o, output, 1 bit, encoder sample valid.
REQ-013: The block SHALL have port in_ready_i, input, 1 bit, encoder ready for a sample.
REQ-014: The block SHALL have port input_done_o, output, 1 bit, one-cycle end-of-frame pulse.
REQ-015: The block SHALL have port count_o, output, $clog2(FIFO_DEPTH)+1 bits, FIFO occupancy.

Function
REQ-016: FIFO entries SHALL store {last, data}; s_ready_o = !full; a push occurs when s_valid_i && s_ready_o.
REQ-017: A pop SHALL occur when in_valid_o && in_ready_i; in_value_o SHALL show the head entry combinationally, with no bypass path, so an empty FIFO yields in_valid_o=0 in the same cycle.
REQ-018: A simultaneous push and pop SHALL leave count_o unchanged, and read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019: FSM states SHALL be IDLE, STREAM, DONE, WAIT_END.
REQ-020: IDLE SHALL go to STREAM when running_i=1, and in_valid_o SHALL be 0 in IDLE.
REQ-021: In STREAM, in_valid_o SHALL equal !empty && running_i; popping an entry with last=1 SHALL go to DONE.
REQ-022: DONE SHALL last exactly one cycle with input_done_o=1 and in_valid_o=0, then go to WAIT_END.
REQ-023: WAIT_END SHALL hold in_valid_o=0 until running_i=0, then go to IDLE; pushes SHALL continue in all states so the next frame is buffered.
REQ-024: If running_i falls in STREAM before last is popped, the FSM SHALL return to IDLE and keep the FIFO contents.
REQ-025: soft_reset_i SHALL empty the FIFO, force IDLE and clear input_done_o on the next edge, and take priority over a simultaneous push or pop.

Reset
REQ-026: On rst_ni=0, the pointers and count_o SHALL be 0, the state SHALL be IDLE, in_valid_o and input_done_o SHALL be 0, and s_ready_o SHALL be 1 once released.
REQ-027: FIFO data storage SHALL NOT require reset, and in_value_o SHALL be don't-care while in_valid_o=0.

Configuration
REQ-028: With INPUT_STREAMER_STATS_EN defined, the block SHALL add outputs frame_cnt_o (16 bits, increments in DONE, wraps) and stall_cnt_o (16 bits, counts cycles in STREAM with !empty && !in_ready_i, saturates); both SHALL be cleared by reset and soft_reset_i.
REQ-029: Without INPUT_STREAMER_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-030: Package hdc_pkg SHALL hold the state enum typedef stream_state_e and the constant DEFAULT_IN_WIDTH=6.
REQ-031: The storage and pointers SHALL form one sub-module, sync_fifo, with push/pop/full/empty/count.

Verification
REQ-032: Reset, then push 3 samples (5,9,63, last on 63) with running_i=0 -> count_o=3, in_valid_o=0.
REQ-033: Raise running_i with in_ready_i=1 -> in_value_o is 5,9,63 on consecutive cycles, then input_done_o is high for exactly 1 cycle.
REQ-034: Push 16 samples with in_ready_i=0 -> s_ready_o=0 at count 16; with in_ready_i=1 and continuous s_valid_i, count_o holds at 16.
REQ-035: Assert soft_reset_i while count_o=7 in STREAM -> count_o=0, state IDLE, no input_done_o pulse.
REQ-036: Drop running_i mid-frame after 2 of 4 pops -> in_valid_o=0, count_o=2 retained; re-raising it resumes with the 3rd sample.
REQ-037: With INPUT_STREAMER_STATS_EN, run two frames with 4 stall cycles -> frame_cnt_o=2, stall_cnt_o=4.
